// File: rtl/pwm_multi_ch_gen_if.sv
// Control-side bundle of the multi-channel PWM generator: run/prescale/duty
// inputs from register logic and the PWM, step and period outputs back.
interface pwm_multi_ch_gen_if #(
    parameter int CHANNELS = 4,
    parameter int RES_BITS = 4,
    parameter int PRESC_W  = 8
);
    logic                         enable;
    logic [PRESC_W-1:0]           prescale;
    logic [CHANNELS*RES_BITS-1:0] duty_in;
    logic                         duty_we;
    logic [CHANNELS-1:0]          pwm_out;
    logic                         step_clk;
    logic                         period_tick;

    modport master (
        output enable, prescale, duty_in, duty_we,
        input  pwm_out, step_clk, period_tick
    );

    modport slave (
        input  enable, prescale, duty_in, duty_we,
        output pwm_out, step_clk, period_tick
    );
endinterface

// File: rtl/pwm_multi_ch_gen.sv
// Multi-channel PWM: prescaled step tick, shared period counter, double-buffered duties.
// Define PWM_CENTER_ALIGN_EN for centre-aligned (up/down) counting; default is edge-aligned.
module pwm_multi_ch_gen #(
    parameter int CHANNELS = 4,
    parameter int RES_BITS = 4,
    parameter int PRESC_W  = 8
) (
    input logic              clk_50M,
    input logic              reset,
    pwm_multi_ch_gen_if.slave bus
);
    typedef logic [RES_BITS-1:0] duty_t;

    localparam duty_t CNT_MAX = '1;

    logic [PRESC_W-1:0]  presc_cnt;
    duty_t               cnt;
    duty_t               pending [CHANNELS];
    duty_t               active  [CHANNELS];
    logic                tick;
    logic                boundary;
    logic [CHANNELS-1:0] pwm_q;
    logic                step_q;
    logic                period_q;

    // >= rather than == so lowering prescale below presc_cnt ticks at once.
    assign tick = bus.enable && (presc_cnt >= bus.prescale);

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            presc_cnt <= '0;
        end else if (!bus.enable || tick) begin
            // NOTE: every clocked register here uses <= so all flops update from pre-edge values.
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    logic cnt_down;

    assign boundary = tick && cnt_down && (cnt == '0);

    // Top and bottom values are each held for one extra tick while direction flips.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            cnt_down <= 1'b0;
        end else if (!bus.enable) begin
            cnt      <= '0;
            cnt_down <= 1'b0;
        end else if (tick) begin
            if (!cnt_down) begin
                if (cnt == CNT_MAX) cnt_down <= 1'b1;
                else                cnt      <= cnt + 1'b1;
            end else begin
                if (cnt == '0) cnt_down <= 1'b0;
                else           cnt      <= cnt - 1'b1;
            end
        end
    end

    function automatic logic duty_hit(duty_t c, duty_t d);
        return {1'b0, c} >= ({1'b1, {RES_BITS{1'b0}}} - {1'b0, d});
    endfunction
`else
    assign boundary = tick && (cnt == CNT_MAX);

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!bus.enable) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    function automatic logic duty_hit(duty_t c, duty_t d);
        return c < d;
    endfunction
`endif

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            // NOTE: duty arrays are a few flops per channel, so they are reset; outputs must start low.
            for (int n = 0; n < CHANNELS; n++) begin
                pending[n] <= '0;
                active[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (bus.duty_we) pending[n] <= bus.duty_in[n*RES_BITS +: RES_BITS];
                // A write landing on the boundary bypasses pending so it is not lost for a period.
                if (!bus.enable)   active[n] <= pending[n];
                else if (boundary) active[n] <= bus.duty_we ? bus.duty_in[n*RES_BITS +: RES_BITS]
                                                            : pending[n];
            end
        end
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            pwm_q    <= '0;
            step_q   <= 1'b0;
            period_q <= 1'b0;
        end else begin
            period_q <= boundary;
            step_q   <= bus.enable ? (step_q ^ tick) : 1'b0;
            for (int n = 0; n < CHANNELS; n++) begin
                pwm_q[n] <= bus.enable && duty_hit(cnt, active[n]);
            end
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.step_clk    = step_q;
    assign bus.period_tick = period_q;
endmodule

// File: tb/tb_pwm_multi_ch_gen.sv
// Self-checking bench for pwm_multi_ch_gen: phase-position reference model compared every
// cycle, plus directed duty/period/prescale/reset checks and a randomized soak.
module tb_pwm_multi_ch_gen;
    localparam int CHANNELS = 4;
    localparam int RES_BITS = 4;
    localparam int PRESC_W  = 8;
    localparam int HALF     = 1 << RES_BITS;
`ifdef PWM_CENTER_ALIGN_EN
    localparam int NSTEP    = 2 * HALF;
`else
    localparam int NSTEP    = HALF;
`endif

    logic clk_50M = 1'b0;
    logic reset;

    pwm_multi_ch_gen_if #(.CHANNELS(CHANNELS), .RES_BITS(RES_BITS), .PRESC_W(PRESC_W)) bus ();

    pwm_multi_ch_gen #(.CHANNELS(CHANNELS), .RES_BITS(RES_BITS), .PRESC_W(PRESC_W)) dut (
        .clk_50M(clk_50M),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #10 clk_50M = ~clk_50M;

    int total = 0;
    int bad   = 0;

    // Reference model: position within the period (0..NSTEP-1) plus prescale count.
    int                  m_presc;
    int                  m_pos;
    int                  m_pend [CHANNELS];
    int                  m_act  [CHANNELS];
    logic [CHANNELS-1:0] e_pwm;
    logic                e_pt;
    logic                e_sc;

    int meas_hi [CHANNELS];
    int meas_pt;
    int meas_tog;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s at %0t: observed=timeout expected=event", tag, $time);
    endtask

    function automatic bit hi(input int pos, input int d);
`ifdef PWM_CENTER_ALIGN_EN
        int c;
        c = (pos < HALF) ? pos : NSTEP - 1 - pos;
        return c >= HALF - d;
`else
        return pos < d;
`endif
    endfunction

    function automatic int hi_steps(input int d);
`ifdef PWM_CENTER_ALIGN_EN
        return 2 * d;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        m_presc = 0;
        m_pos   = 0;
        for (int n = 0; n < CHANNELS; n++) begin
            m_pend[n] = 0;
            m_act[n]  = 0;
        end
        e_pwm = '0;
        e_pt  = 1'b0;
        e_sc  = 1'b0;
    endtask

    // Advance model and DUT one clock, then compare all outputs.
    task automatic step();
        bit tick;
        bit bnd;
        int din [CHANNELS];
        for (int n = 0; n < CHANNELS; n++) din[n] = int'(bus.duty_in[n*RES_BITS +: RES_BITS]);
        if (reset) begin
            model_reset();
        end else begin
            tick = bus.enable && (m_presc >= int'(bus.prescale));
            bnd  = tick && (m_pos == NSTEP - 1);
            for (int n = 0; n < CHANNELS; n++) e_pwm[n] = bus.enable && hi(m_pos, m_act[n]);
            e_pt = bnd;
            e_sc = bus.enable ? (e_sc ^ tick) : 1'b0;
            for (int n = 0; n < CHANNELS; n++) begin
                if (!bus.enable) m_act[n] = m_pend[n];
                else if (bnd)    m_act[n] = bus.duty_we ? din[n] : m_pend[n];
                if (bus.duty_we) m_pend[n] = din[n];
            end
            m_presc = (!bus.enable || tick) ? 0 : m_presc + 1;
            m_pos   = !bus.enable ? 0 : (tick ? (m_pos + 1) % NSTEP : m_pos);
        end
        @(posedge clk_50M);
        #1;
        check("cycle_outputs", {bus.pwm_out, bus.period_tick, bus.step_clk}, {e_pwm, e_pt, e_sc});
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic write_duty(input logic [CHANNELS*RES_BITS-1:0] d);
        bus.duty_in = d;
        bus.duty_we = 1'b1;
        step();
        bus.duty_we = 1'b0;
    endtask

    task automatic run_to_boundary();
        for (int i = 0; i < NSTEP * 300; i++) begin
            step();
            if (e_pt) return;
        end
        timeout("boundary_wait");
    endtask

    task automatic measure(input int cycles);
        logic prev;
        for (int n = 0; n < CHANNELS; n++) meas_hi[n] = 0;
        meas_pt  = 0;
        meas_tog = 0;
        prev     = bus.step_clk;
        repeat (cycles) begin
            step();
            for (int n = 0; n < CHANNELS; n++) meas_hi[n] += int'(bus.pwm_out[n]);
            meas_pt  += int'(bus.period_tick);
            meas_tog += int'(bus.step_clk !== prev);
            prev      = bus.step_clk;
        end
    endtask

    task automatic period_gap(output int gap);
        gap = 0;
        for (int i = 1; i <= NSTEP * 600; i++) begin
            step();
            if (bus.period_tick === 1'b1) begin
                gap = i;
                return;
            end
        end
    endtask

    initial begin
        int gap;
        int ch0_hi;
        bit wrote;
        logic [CHANNELS*RES_BITS-1:0] rnd;

        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.prescale = 8'd15;
        bus.duty_in  = '0;
        bus.duty_we  = 1'b0;
        model_reset();
        #1;
        check("reset_outputs", {bus.pwm_out, bus.period_tick, bus.step_clk}, 32'd0);
        run(3);

        // 50 % duty on ch0 at prescale 15.
        reset      = 1'b0;
        bus.enable = 1'b1;
        rnd        = CHANNELS*RES_BITS'($urandom());
        rnd[3:0]   = 4'd8;
        write_duty(rnd);
        run_to_boundary();
        measure(NSTEP * 16);
        check("t1_ch0_high", meas_hi[0], hi_steps(8) * 16);
        check("t1_period_ticks", meas_pt, 1);
        check("t1_step_toggles", meas_tog, NSTEP);
        run_to_boundary();
        period_gap(gap);
        check("t1_period_gap", gap, NSTEP * 16);

        // Mixed duties including 0 and maximum.
        write_duty({4'd4, 4'd15, 4'd1, 4'd0});
        run_to_boundary();
        measure(NSTEP * 16);
        check("t2_ch0_zero", meas_hi[0], 0);
        check("t2_ch1_one", meas_hi[1], hi_steps(1) * 16);
        check("t2_ch2_max", meas_hi[2], hi_steps(15) * 16);
        check("t2_ch3_four", meas_hi[3], hi_steps(4) * 16);

        // Mid-period write is deferred; boundary write bypasses.
        write_duty({4'd4, 4'd15, 4'd1, 4'd8});
        run_to_boundary();
        ch0_hi = 0;
        wrote  = 1'b0;
        for (int i = 0; i < NSTEP * 16; i++) begin
            if (!wrote && m_pos == 5) begin
                bus.duty_in[3:0] = 4'd11;
                bus.duty_we      = 1'b1;
                wrote            = 1'b1;
            end
            step();
            bus.duty_we = 1'b0;
            ch0_hi += int'(bus.pwm_out[0]);
        end
        check("t3_current_keeps", ch0_hi, hi_steps(8) * 16);
        measure(NSTEP * 16);
        check("t3_next_period", meas_hi[0], hi_steps(11) * 16);
        for (int i = 0; i < NSTEP * 16 && !(m_pos == NSTEP - 1 && m_presc >= 15); i++) step();
        bus.duty_in[3:0] = 4'd5;
        bus.duty_we      = 1'b1;
        step();
        bus.duty_we = 1'b0;
        check("t3_bnd_tick", bus.period_tick, 1'b1);
        measure(NSTEP * 16);
        check("t3_bypass", meas_hi[0], hi_steps(5) * 16);

        // Lowering prescale below the running count.
        for (int i = 0; i < 20 && m_presc != 10; i++) step();
        bus.prescale = 8'd3;
        run_to_boundary();
        period_gap(gap);
        check("t4_period_gap", gap, NSTEP * 4);
        measure(NSTEP * 4);
        check("t4_step_toggles", meas_tog, NSTEP);
        check("t4_ch0_high", meas_hi[0], hi_steps(5) * 4);

        // Asynchronous reset while ch0 is high.
        for (int i = 0; i < NSTEP * 8 && !e_pwm[0]; i++) step();
        check("t5_pre_high", bus.pwm_out[0], 1'b1);
        #5;
        reset = 1'b1;
        #1;
        check("t5_async_reset", {bus.pwm_out, bus.period_tick, bus.step_clk}, 32'd0);
        model_reset();
        run(2);
        reset = 1'b0;
        measure(NSTEP * 8);
        check("t5_low_after_reset", meas_hi[0] + meas_hi[1] + meas_hi[2] + meas_hi[3], 0);
        write_duty({4'd2, 4'd9, 4'd7, 4'd6});
        run_to_boundary();
        measure(NSTEP * 4);
        check("t5_resumed", meas_hi[1], hi_steps(7) * 4);

        // Randomized soak: prescale, duty writes and enable toggling.
        for (int seg = 0; seg < 24; seg++) begin
            bus.prescale = PRESC_W'($urandom_range(0, 5));
            if ($urandom_range(0, 9) < 2) bus.enable = ~bus.enable;
            else                          bus.enable = 1'b1;
            for (int i = 0; i < int'($urandom_range(20, 160)); i++) begin
                bus.duty_in = CHANNELS*RES_BITS'($urandom());
                bus.duty_we = ($urandom_range(0, 15) == 0);
                step();
            end
            bus.duty_we = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
